// File: rtl/led_frame_sequencer.sv
// Collects one frame of bin amplitudes, runs the LED count calculator under a timeout, then streams per-bin counts.
// Start rises 1 cycle after the last bin; first beat 1 cycle after the result; beats hold while out_ready_i is low.
module led_frame_sequencer #(
  parameter int W       = 6,
  parameter int D       = 10,
  parameter int LEDS    = 50,
  parameter int BIN_QTY = 12,
  parameter int TIMEOUT = 255,
  localparam int AW     = W + D,
  localparam int CW     = $clog2(LEDS),
  localparam int BW     = $clog2(BIN_QTY),
  localparam int SW     = AW + BW,
  localparam int TMW    = $clog2(TIMEOUT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bin_valid_i,
  input  logic [AW-1:0]         bin_data_i,
  input  logic                  bin_last_i,
  output logic                  bin_ready_o,
  output logic                  calc_start_o,
  output logic [BIN_QTY*AW-1:0] calc_amps_o,
  output logic [SW:0]           calc_sum_o,
  input  logic                  calc_data_v_i,
  input  logic [BIN_QTY*CW-1:0] calc_count_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [BW-1:0]         out_bin_o,
  output logic [CW-1:0]         out_count_o,
  output logic                  out_last_o,
  output logic                  busy_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_DRAIN   = 2'd1,
    S_CALC    = 2'd2,
    S_EMIT    = 2'd3
  } state_t;

  state_t         state, state_nxt;
  logic [BW-1:0]  idx, idx_nxt;
  logic [BW-1:0]  eidx, eidx_nxt;
  logic [SW-1:0]  sum, sum_nxt;
  logic [TMW-1:0] timer, timer_nxt;
  logic           amp_we;
  logic           cnt_we;
  logic           err;

  logic [AW-1:0]  amps  [BIN_QTY];
  logic [CW-1:0]  count [BIN_QTY];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_COLLECT;
      idx   <= '0;
      eidx  <= '0;
      sum   <= '0;
      timer <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      eidx  <= eidx_nxt;
      sum   <= sum_nxt;
      timer <= timer_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    eidx_nxt  = eidx;
    sum_nxt   = sum;
    timer_nxt = '0;
    amp_we    = 1'b0;
    cnt_we    = 1'b0;
    err       = 1'b0;
    case (state)
      S_COLLECT: begin
        if (bin_valid_i) begin
          amp_we  = 1'b1;
          idx_nxt = idx + 1'b1;
          sum_nxt = sum + SW'(bin_data_i);
          if (idx == BW'(BIN_QTY - 1)) begin
            if (bin_last_i) begin
              state_nxt = S_CALC;
            end else begin
              err       = 1'b1;
              state_nxt = S_DRAIN;
            end
          end else if (bin_last_i) begin
            // Premature last: throw away the partial frame and resync on the next beat.
            err     = 1'b1;
            idx_nxt = '0;
            sum_nxt = '0;
          end
        end
      end
      S_DRAIN: begin
        if (bin_valid_i && bin_last_i) begin
          idx_nxt   = '0;
          sum_nxt   = '0;
          state_nxt = S_COLLECT;
        end
      end
      S_CALC: begin
        // A result on the final timeout cycle still wins over the timeout.
        if (calc_data_v_i) begin
          cnt_we    = 1'b1;
          eidx_nxt  = '0;
          state_nxt = S_EMIT;
        end else if (timer == TMW'(TIMEOUT - 1)) begin
          err       = 1'b1;
          idx_nxt   = '0;
          sum_nxt   = '0;
          state_nxt = S_COLLECT;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      S_EMIT: begin
        if (out_ready_i) begin
          if (eidx == BW'(BIN_QTY - 1)) begin
            eidx_nxt  = '0;
            idx_nxt   = '0;
            sum_nxt   = '0;
            state_nxt = S_COLLECT;
          end else begin
            eidx_nxt = eidx + 1'b1;
          end
        end
      end
      default: state_nxt = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < BIN_QTY; k++) amps[k] <= '0;
    end else if (amp_we) begin
      amps[idx] <= bin_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < BIN_QTY; k++) count[k] <= '0;
    end else if (cnt_we) begin
      for (int k = 0; k < BIN_QTY; k++) count[k] <= calc_count_i[k*CW +: CW];
    end
  end

  always_comb begin
    calc_amps_o = '0;
    for (int k = 0; k < BIN_QTY; k++) calc_amps_o[k*AW +: AW] = amps[k];
  end

  // Ready and error are gated by reset so every output reads 0 while reset is held.
  assign bin_ready_o  = rst && ((state == S_COLLECT) || (state == S_DRAIN));
  assign err_o        = rst && err;
  assign calc_start_o = (state == S_CALC);
  assign calc_sum_o   = {1'b0, sum};
  assign busy_o       = (state != S_COLLECT);
  assign out_valid_o  = (state == S_EMIT);
  assign out_bin_o    = out_valid_o ? eidx : '0;
  assign out_count_o  = out_valid_o ? count[eidx] : '0;
  assign out_last_o   = out_valid_o && (eidx == BW'(BIN_QTY - 1));

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Bench for led_frame_sequencer: table of frames plus hand sequences for error, timeout and reset cases.
module tb_led_frame_sequencer;
  localparam int BQ = 12;
  localparam int AW = 16;
  localparam int CW = 6;
  localparam int BW = 4;
  localparam int SW = 21;
  localparam int TO = 255;

  logic              clk, rst;
  logic              bin_valid_i, bin_last_i, bin_ready_o;
  logic [AW-1:0]     bin_data_i;
  logic              calc_start_o, calc_data_v_i;
  logic [BQ*AW-1:0]  calc_amps_o;
  logic [SW-1:0]     calc_sum_o;
  logic [BQ*CW-1:0]  calc_count_i;
  logic              out_valid_o, out_ready_i, out_last_o, busy_o, err_o;
  logic [BW-1:0]     out_bin_o;
  logic [CW-1:0]     out_count_o;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [BQ-1:0][AW-1:0] amp;
    logic [BQ-1:0][CW-1:0] cnt;
    logic [SW-1:0]         sum;
    logic [1:0]            mode;   // 0 always ready, 1 toggle, 2 random
    logic [8:0]            delay;  // CALC cycles before the result arrives
  } vec_t;

  typedef struct packed {
    logic [BW-1:0] bin;
    logic [CW-1:0] cnt;
    logic          last;
  } exp_t;

  vec_t vecs [3];
  exp_t sb [$];

  led_frame_sequencer dut (
    .clk(clk), .rst(rst),
    .bin_valid_i(bin_valid_i), .bin_data_i(bin_data_i), .bin_last_i(bin_last_i), .bin_ready_o(bin_ready_o),
    .calc_start_o(calc_start_o), .calc_amps_o(calc_amps_o), .calc_sum_o(calc_sum_o),
    .calc_data_v_i(calc_data_v_i), .calc_count_i(calc_count_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_bin_o(out_bin_o),
    .out_count_o(out_count_o), .out_last_o(out_last_o), .busy_o(busy_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [AW-1:0] d, input logic last, input logic exp_err);
    bin_valid_i = 1'b1;
    bin_data_i  = d;
    bin_last_i  = last;
    #1;
    check("beat_ready", 32'(bin_ready_o), 32'(1));
    check("beat_err", 32'(err_o), 32'(exp_err));
    check("beat_start_low", 32'(calc_start_o), 32'(0));
    cyc();
    bin_valid_i = 1'b0;
    bin_last_i  = 1'b0;
    bin_data_i  = '0;
  endtask

  task automatic run_frame(input int v, input int abort_after);
    vec_t f;
    exp_t e;
    int got;
    logic stall;
    logic [BW-1:0] pb;
    logic [CW-1:0] pc;
    f = vecs[v];
    for (int k = 0; k < BQ; k++) beat(f.amp[k], (k == BQ - 1), 1'b0);
    #1;
    check("start_rise", 32'(calc_start_o), 32'(1));
    check("calc_ready_low", 32'(bin_ready_o), 32'(0));
    check("calc_sum", 32'(calc_sum_o), 32'(f.sum));
    for (int k = 0; k < BQ; k++) check("calc_amps", 32'(calc_amps_o[k*AW +: AW]), 32'(f.amp[k]));
    for (int d = 0; d < int'(f.delay); d++) begin
      check("calc_wait_err", 32'(err_o), 32'(0));
      cyc();
      #1;
    end
    check("sum_hold", 32'(calc_sum_o), 32'(f.sum));
    check("start_hold", 32'(calc_start_o), 32'(1));
    calc_data_v_i = 1'b1;
    for (int k = 0; k < BQ; k++) begin
      calc_count_i[k*CW +: CW] = f.cnt[k];
      e.bin  = BW'(k);
      e.cnt  = f.cnt[k];
      e.last = (k == BQ - 1);
      sb.push_back(e);
    end
    #1;
    check("data_err", 32'(err_o), 32'(0));
    check("data_vld_low", 32'(out_valid_o), 32'(0));
    cyc();
    calc_data_v_i = 1'b0;
    calc_count_i  = '1;
    #1;
    check("start_fall", 32'(calc_start_o), 32'(0));
    got   = 0;
    stall = 1'b0;
    pb    = '0;
    pc    = '0;
    for (int c = 0; c < 300 && got < BQ; c++) begin
      if (abort_after >= 0 && got == abort_after) break;
      if (f.mode == 2'd0)      out_ready_i = 1'b1;
      else if (f.mode == 2'd1) out_ready_i = ((c % 2) == 1);
      else                     out_ready_i = ($urandom_range(0, 1) != 0);
      #1;
      check("emit_vld", 32'(out_valid_o), 32'(1));
      if (stall) begin
        check("hold_bin", 32'(out_bin_o), 32'(pb));
        check("hold_cnt", 32'(out_count_o), 32'(pc));
      end
      if (out_ready_i && out_valid_o) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'(sb.size()), 32'(1));
        end else begin
          e = sb.pop_front();
          check("out_bin", 32'(out_bin_o), 32'(e.bin));
          check("out_count", 32'(out_count_o), 32'(e.cnt));
          check("out_last", 32'(out_last_o), 32'(e.last));
          got++;
        end
      end
      stall = out_valid_o && !out_ready_i;
      pb    = out_bin_o;
      pc    = out_count_o;
      cyc();
    end
    out_ready_i = 1'b0;
    if (abort_after < 0) begin
      #1;
      check("beats", 32'(got), 32'(BQ));
      check("sb_empty", 32'(sb.size()), 32'(0));
      check("post_busy", 32'(busy_o), 32'(0));
      check("post_ready", 32'(bin_ready_o), 32'(1));
      check("post_vld", 32'(out_valid_o), 32'(0));
    end
  endtask

  initial begin
    rst = 1'b0; bin_valid_i = 1'b0; bin_last_i = 1'b0; bin_data_i = '0;
    calc_data_v_i = 1'b0; calc_count_i = '0; out_ready_i = 1'b0;

    vecs[0] = '0;
    vecs[0].amp[0] = 16'h0D4A; vecs[0].amp[6] = 16'h0D4A; vecs[0].amp[8] = 16'h0D4A; vecs[0].amp[5] = 16'h014A;
    vecs[0].cnt[0] = 6'd16; vecs[0].cnt[5] = 6'd2; vecs[0].cnt[6] = 6'd16; vecs[0].cnt[8] = 6'd16;
    vecs[0].sum = 21'h02928; vecs[0].mode = 2'd0; vecs[0].delay = 9'd2;
    vecs[1] = '0;
    for (int k = 0; k < BQ; k++) begin vecs[1].amp[k] = 16'hFFFF; vecs[1].cnt[k] = 6'd63; end
    vecs[1].sum = 21'h0BFFF4; vecs[1].mode = 2'd1; vecs[1].delay = 9'd0;
    vecs[2] = '0;
    for (int k = 0; k < BQ; k++) begin vecs[2].amp[k] = AW'(k + 1); vecs[2].cnt[k] = CW'(11 - k); end
    vecs[2].sum = 21'd78; vecs[2].mode = 2'd2; vecs[2].delay = 9'(TO - 1);

    #1;
    check("rst_ready", 32'(bin_ready_o), 32'(0));
    check("rst_busy", 32'(busy_o), 32'(0));
    check("rst_start", 32'(calc_start_o), 32'(0));
    check("rst_vld", 32'(out_valid_o), 32'(0));
    check("rst_err", 32'(err_o), 32'(0));
    check("rst_sum", 32'(calc_sum_o), 32'(0));
    cyc(); cyc();
    rst = 1'b1;
    #1;
    check("rel_ready", 32'(bin_ready_o), 32'(1));
    check("rel_busy", 32'(busy_o), 32'(0));
    cyc();

    for (int v = 0; v < 3; v++) run_frame(v, -1);

    // Premature last on the 5th beat, then a clean frame.
    for (int k = 0; k < 4; k++) beat(16'h0100, 1'b0, 1'b0);
    beat(16'h0100, 1'b1, 1'b1);
    #1;
    check("pre_busy", 32'(busy_o), 32'(0));
    check("pre_start", 32'(calc_start_o), 32'(0));
    check("pre_err_once", 32'(err_o), 32'(0));
    run_frame(0, -1);

    // Missing last: 14 beats, last only on the 14th.
    for (int k = 0; k < 14; k++) begin
      beat(16'h0200, (k == 13), (k == 11));
      if (k == 11) begin
        #1;
        check("miss_drain_busy", 32'(busy_o), 32'(1));
        check("miss_drain_start", 32'(calc_start_o), 32'(0));
      end
    end
    #1;
    check("miss_back_busy", 32'(busy_o), 32'(0));
    run_frame(1, -1);

    // Calculator never answers.
    for (int k = 0; k < BQ; k++) beat(vecs[0].amp[k], (k == BQ - 1), 1'b0);
    #1;
    for (int c = 1; c <= TO; c++) begin
      check("to_err", 32'(err_o), 32'(c == TO));
      cyc();
      #1;
    end
    check("to_start_fall", 32'(calc_start_o), 32'(0));
    check("to_ready", 32'(bin_ready_o), 32'(1));
    check("to_busy", 32'(busy_o), 32'(0));
    check("to_err_once", 32'(err_o), 32'(0));

    // A stray result outside CALC must not start emitting.
    calc_data_v_i = 1'b1;
    cyc();
    calc_data_v_i = 1'b0;
    #1;
    check("stray_busy", 32'(busy_o), 32'(0));
    check("stray_vld", 32'(out_valid_o), 32'(0));

    // Reset after three output beats.
    run_frame(0, 3);
    rst = 1'b0;
    #1;
    check("mid_rst_vld", 32'(out_valid_o), 32'(0));
    check("mid_rst_busy", 32'(busy_o), 32'(0));
    check("mid_rst_ready", 32'(bin_ready_o), 32'(0));
    check("mid_rst_bin", 32'(out_bin_o), 32'(0));
    check("mid_rst_cnt", 32'(out_count_o), 32'(0));
    check("mid_rst_sum", 32'(calc_sum_o), 32'(0));
    check("mid_rst_amps", 32'(calc_amps_o != '0), 32'(0));
    check("mid_rst_err", 32'(err_o), 32'(0));
    sb.delete();
    cyc();
    rst = 1'b1;
    #1;
    check("mid_rel_ready", 32'(bin_ready_o), 32'(1));
    check("mid_rel_busy", 32'(busy_o), 32'(0));
    cyc();
    run_frame(2, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
